// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: iterative double-dabble binary to packed BCD converter with overflow saturation
module bin_to_bcd_seq #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_Start,
    input  logic [WIDTH-1:0]      i_Binary,
    output logic                  o_Busy,
    output logic                  o_Done,
    output logic [4*DIGITS-1:0]   o_BCD,
    output logic                  o_Overflow,
    output logic [DIGITS-1:0]     o_Digit_Valid
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state, next_state;
    logic [CW-1:0]   count;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]   scratch, adjusted, nines;
    logic [DIGITS-1:0] sig;
    logic            carry, load;

    assign load   = i_Start && state != SHIFT;
    assign o_Busy = state == SHIFT;
    assign o_Done = state == DONE;

    genvar k;
    generate
        for (k = 0; k < DIGITS; k++) begin : g_digit
            assign adjusted[4*k+3:4*k] = scratch[4*k+3:4*k] >= 4'd5 ? scratch[4*k+3:4*k] + 4'd3 : scratch[4*k+3:4*k];
            assign nines[4*k+3:4*k]    = 4'd9;
            assign sig[k]              = k == 0 ? 1'b1 : |scratch[BW-1:4*k];
        end
    endgenerate

    // State register
    always_ff @(posedge i_Clk) begin
        if (i_Rst) state <= IDLE;
        else       state <= next_state;
    end

    // Next state: SHIFT runs until the counter is exhausted, then one finalize edge enters DONE
    always_comb begin
        next_state = state;
        if (state == SHIFT) next_state = count == '0 ? DONE : SHIFT;
        else                next_state = i_Start ? SHIFT : IDLE;
    end

    // Datapath: capture, add-3/shift iterations with sticky carry-out, and result registers
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            count         <= '0;
            shreg         <= '0;
            scratch       <= '0;
            carry         <= 1'b0;
            o_BCD         <= '0;
            o_Overflow    <= 1'b0;
            o_Digit_Valid <= DIGITS'(1);
        end else if (load) begin
            shreg   <= i_Binary;
            scratch <= '0;
            carry   <= 1'b0;
            count   <= CW'(WIDTH);
        end else if (state == SHIFT) begin
            if (count != '0) begin
                {scratch, shreg} <= {adjusted, shreg} << 1;
                carry            <= carry | adjusted[BW-1];
                count            <= count - 1'b1;
            end else begin
                o_BCD         <= carry ? nines : scratch;
                o_Overflow    <= carry;
                o_Digit_Valid <= carry ? '1 : sig;
            end
        end
    end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: scoreboard bench for bin_to_bcd_seq using directed vectors
module tb_bin_to_bcd_seq;
    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        logic [3:0]  dv;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [13:0] binary = '0;
    logic        busy, done, ovf;
    logic [15:0] bcd;
    logic [3:0]  dv;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;

    bin_to_bcd_seq #(.WIDTH(14), .DIGITS(4)) dut (
        .i_Clk(clk), .i_Rst(rst), .i_Start(start), .i_Binary(binary),
        .o_Busy(busy), .o_Done(done), .o_BCD(bcd), .o_Overflow(ovf), .o_Digit_Valid(dv)
    );

    always #5 clk = ~clk;

    // Cycle counter used for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every o_Done pulse is matched against the oldest expected result
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("bcd", bcd, e.bcd);
                    chk("overflow", ovf, e.ovf);
                    chk("digit_valid", dv, e.dv);
                    chk("busy_low_at_done", busy, 0);
                    if (e.acc >= 0) chk("latency", cyc - e.acc, 15);
                end
            end
        end
    end

    task automatic start_conv(input logic [13:0] v, input logic push, input logic [15:0] eb,
                              input logic eo, input logic [3:0] ed);
        exp_t e;
        binary = v;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_accept", busy, 1);
        if (push) begin
            e.bcd = eb; e.ovf = eo; e.dv = ed; e.acc = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_empty(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk); #1;
            n++;
        end
        chk("done_timeout", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        exp_t e;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_bcd", bcd, 16'h0000);
        chk("rst_ovf", ovf, 0);
        chk("rst_dv", dv, 4'b0001);

        start_conv(14'd0, 1, 16'h0000, 0, 4'b0001);
        wait_empty(40);

        start_conv(14'd1234, 1, 16'h1234, 0, 4'b1111);
        binary = 14'd777;
        wait_empty(40);
        start_conv(14'd50, 1, 16'h0050, 0, 4'b0011);
        wait_empty(40);

        start_conv(14'd9999, 1, 16'h9999, 0, 4'b1111);
        wait_empty(40);
        start_conv(14'd10000, 1, 16'h9999, 1, 4'b1111);
        wait_empty(40);
        start_conv(14'd16383, 1, 16'h9999, 1, 4'b1111);
        wait_empty(40);
        start_conv(14'd7, 1, 16'h0007, 0, 4'b0001);
        wait_empty(40);

        // Start held high: accepted only when not busy, results back to back
        e.bcd = 16'h0042; e.ovf = 1'b0; e.dv = 4'b0011; e.acc = -1;
        repeat (3) exp_q.push_back(e);
        binary = 14'd42;
        start  = 1'b1;
        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 80) begin
                @(negedge clk); #1;
                n++;
            end
        end
        start = 1'b0;
        chk("held_timeout", exp_q.size(), 0);
        exp_q.delete();
        repeat (20) @(posedge clk);
        #1;

        // Extra start pulse in the middle of a conversion is ignored
        start_conv(14'd4321, 1, 16'h4321, 0, 4'b1111);
        repeat (4) @(posedge clk);
        #1 binary = 14'd9; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_empty(40);
        repeat (20) @(posedge clk);
        #1;

        // Reset mid-conversion: no done for the aborted value
        start_conv(14'd8765, 0, 16'h0, 0, 4'b0);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_bcd", bcd, 16'h0000);
        chk("abort_ovf", ovf, 0);
        chk("abort_dv", dv, 4'b0001);
        repeat (25) @(posedge clk);
        #1;
        start_conv(14'd8765, 1, 16'h8765, 0, 4'b1111);
        wait_empty(40);
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
